// File: rtl/uart2_tx_packetizer_pkg.sv
// Shared definitions for the UART packetizer: default sync byte, FSM states and
// a sizing helper for the word counter and byte index.
package uart2_tx_packetizer_pkg;

    localparam logic [7:0] DefaultHeader = 8'hA5;

    typedef enum logic [1:0] {
        StCollect  = 2'd0,
        StLoad     = 2'd1,
        StWaitIdle = 2'd2
    } state_e;

    // Number of bits needed to hold values 0..value (at least 1).
    function automatic int unsigned bits_to_fit(input int unsigned value);
        int unsigned width;
        width = 1;
        for (int i = 1; i < 32; i++) begin
            if ((value >> i) != 0) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/uart2_tx_packetizer.sv
// Collects NUM_WORDS words, then feeds header + payload (MSB-first) bytes to a UART transmitter.
// Optional checksum byte after the payload when UART_PKT_CHECKSUM_EN is defined.
module uart2_tx_packetizer
    import uart2_tx_packetizer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned NUM_WORDS  = 4,
    parameter logic [7:0]  HEADER     = DefaultHeader
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic                  tx_empty,
    output logic                  ld_tx_data,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  overflow
);

    localparam int unsigned Bpw    = WORD_WIDTH / 8;
    localparam int unsigned NumPay = NUM_WORDS * Bpw;
`ifdef UART_PKT_CHECKSUM_EN
    localparam int unsigned PktLen = NumPay + 2;
`else
    localparam int unsigned PktLen = NumPay + 1;
`endif
    localparam int unsigned CntW = bits_to_fit(NUM_WORDS);
    localparam int unsigned IdxW = bits_to_fit(PktLen);

    localparam logic [CntW-1:0] CntLast = CntW'(NUM_WORDS - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(NUM_WORDS);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(PktLen - 1);

    state_e                state_q, state_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  pkt_done_q, pkt_done_d;
    logic                  overflow_q, overflow_d;
    logic [WORD_WIDTH-1:0] buf_q [NUM_WORDS];
    logic [WORD_WIDTH-1:0] buf_d [NUM_WORDS];
`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic [7:0]      pay_bytes [NumPay];
    logic [IdxW-1:0] idx_nxt;
    logic [7:0]      next_byte;
    logic            accept;

    assign word_ready = (state_q == StCollect) && (count_q < CntFull);
    assign accept     = word_valid && word_ready;
    assign ld_tx_data = (state_q == StLoad);
    assign busy       = (state_q != StCollect);
    assign tx_data    = tx_data_q;
    assign pkt_done   = pkt_done_q;
    assign overflow   = overflow_q;

    // Flattened payload view: byte 0 is word 0 MSB.
    always_comb begin
        for (int w = 0; w < NUM_WORDS; w++) begin
            for (int b = 0; b < Bpw; b++) begin
                pay_bytes[w*Bpw+b] = buf_q[w][WORD_WIDTH-1-8*b -: 8];
            end
        end
    end

    // Byte to present after the current one; index 0 is the header.
    always_comb begin
        idx_nxt   = idx_q + 1'b1;
        next_byte = 8'h00;
        for (int p = 0; p < NumPay; p++) begin
            if (idx_nxt == IdxW'(p + 1)) next_byte = pay_bytes[p];
        end
`ifdef UART_PKT_CHECKSUM_EN
        if (idx_nxt == IdxLast) next_byte = csum_q;
`endif
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        pkt_done_d = 1'b0;
        overflow_d = overflow_q | (word_valid & ~word_ready);
        buf_d      = buf_q;
`ifdef UART_PKT_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    for (int w = 0; w < NUM_WORDS; w++) begin
                        if (count_q == CntW'(w)) buf_d[w] = word_in;
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == CntLast) begin
                        state_d   = StLoad;
                        idx_d     = '0;
                        tx_data_d = HEADER;
                    end
                end
            end
            StLoad: begin
                if (!tx_empty) state_d = StWaitIdle;
            end
            StWaitIdle: begin
                if (tx_empty) begin
                    if (idx_q != IdxLast) begin
                        idx_d     = idx_nxt;
                        tx_data_d = next_byte;
                        state_d   = StLoad;
`ifdef UART_PKT_CHECKSUM_EN
                        if (idx_nxt <= IdxW'(NumPay)) csum_d = csum_q + next_byte;
`endif
                    end else begin
                        pkt_done_d = 1'b1;
                        count_d    = '0;
                        idx_d      = '0;
                        state_d    = StCollect;
`ifdef UART_PKT_CHECKSUM_EN
                        csum_d     = '0;
`endif
                    end
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StCollect;
            count_q    <= '0;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            pkt_done_q <= 1'b0;
            overflow_q <= 1'b0;
            for (int w = 0; w < NUM_WORDS; w++) buf_q[w] <= '0;
`ifdef UART_PKT_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            pkt_done_q <= pkt_done_d;
            overflow_q <= overflow_d;
            buf_q      <= buf_d;
`ifdef UART_PKT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart2_tx_packetizer.sv
// Directed bench for uart2_tx_packetizer with a byte-level transmitter model downstream.
module tb_uart2_tx_packetizer;

    localparam int unsigned WordWidth = 16;
    localparam int unsigned NumWords  = 2;
    localparam int          TxCycles  = 10;
`ifdef UART_PKT_CHECKSUM_EN
    localparam int          PktLen    = 6;
`else
    localparam int          PktLen    = 5;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [WordWidth-1:0] word_in = '0;
    logic                 word_valid = 1'b0;
    logic                 word_ready;
    logic                 tx_empty = 1'b1;
    logic                 ld_tx_data;
    logic [7:0]           tx_data;
    logic                 busy;
    logic                 pkt_done;
    logic                 overflow;

    logic                 tx_enable = 1'b1;
    int                   tx_cnt = 0;
    logic [7:0]           rx_q [$];
    int                   pkt_cnt = 0;
    int                   bytes_at_done = 0;
    int                   n_checks = 0;
    int                   n_fail = 0;

    uart2_tx_packetizer #(
        .WORD_WIDTH (WordWidth),
        .NUM_WORDS  (NumWords),
        .HEADER     (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .tx_empty   (tx_empty),
        .ld_tx_data (ld_tx_data),
        .tx_data    (tx_data),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .overflow   (overflow)
    );

    always #10 clk = ~clk;

    // Transmitter model: loads a byte when idle+enabled, busy for TxCycles cycles.
    always @(posedge clk) begin
        if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_empty <= 1'b1;
        end else if (tx_enable && ld_tx_data && tx_empty) begin
            rx_q.push_back(tx_data);
            tx_empty <= 1'b0;
            tx_cnt   <= TxCycles;
        end
    end

    always @(negedge clk) begin
        if (pkt_done) begin
            pkt_cnt       = pkt_cnt + 1;
            bytes_at_done = rx_q.size();
        end
    end

    function automatic logic [63:0] rx_packed();
        logic [63:0] v;
        v = '0;
        foreach (rx_q[i]) v = {v[55:0], rx_q[i]};
        return v;
    endfunction

    function automatic logic [63:0] exp_pkt(input logic [15:0] w0, input logic [15:0] w1,
                                            input logic [7:0] csum);
`ifdef UART_PKT_CHECKSUM_EN
        return {16'h0000, 8'hA5, w0, w1, csum};
`else
        return {24'h000000, 8'hA5, w0, w1} | {56'h0, csum & 8'h00};
`endif
    endfunction

    task automatic send_pair(input logic [15:0] w0, input logic [15:0] w1);
        @(negedge clk);
        word_valid = 1'b1;
        word_in    = w0;
        @(negedge clk);
        word_in    = w1;
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (pkt_cnt != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks += 6;
        if (word_ready !== 1'b1) begin n_fail++; $display("FAIL reset_word_ready: got %b want 1", word_ready); end
        if (ld_tx_data !== 1'b0) begin n_fail++; $display("FAIL reset_ld: got %b want 0", ld_tx_data); end
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_basic();
        int base;
        bit ok;
        rx_q.delete();
        base = pkt_cnt;
        send_pair(16'h1234, 16'hABCD);
        n_checks += 4;
        if (ld_tx_data !== 1'b1) begin n_fail++; $display("FAIL basic_ld_latency: got %b want 1", ld_tx_data); end
        if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_header: got %h want a5", tx_data); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
        if (word_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_low: got %b want 0", word_ready); end
        wait_done(base, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: got %b want 1", ok); end
        n_checks += 2;
        if (rx_packed() !== exp_pkt(16'h1234, 16'hABCD, 8'hBE))
            begin n_fail++; $display("FAIL basic_bytes: got %h want %h", rx_packed(), exp_pkt(16'h1234, 16'hABCD, 8'hBE)); end
        if (bytes_at_done !== PktLen) begin n_fail++; $display("FAIL basic_done_after_last: got %0d want %0d", bytes_at_done, PktLen); end
        repeat (20) @(negedge clk);
        n_checks += 4;
        if (pkt_cnt !== base + 1) begin n_fail++; $display("FAIL basic_one_pulse: got %0d want %0d", pkt_cnt, base + 1); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", busy); end
        if (word_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b want 1", word_ready); end
        if (rx_q.size() !== PktLen) begin n_fail++; $display("FAIL basic_len: got %0d want %0d", rx_q.size(), PktLen); end
    endtask

    task automatic test_stall();
        int base;
        int bad;
        bit ok;
        rx_q.delete();
        base = pkt_cnt;
        bad = 0;
        tx_enable = 1'b0;
        send_pair(16'hBEEF, 16'h0102);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ld_tx_data !== 1'b1 || tx_data !== 8'hA5) bad++;
        end
        n_checks += 2;
        if (bad !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
        if (rx_q.size() !== 0) begin n_fail++; $display("FAIL stall_no_bytes: got %0d want 0", rx_q.size()); end
        tx_enable = 1'b1;
        wait_done(base, ok);
        n_checks += 2;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_timeout: got %b want 1", ok); end
        if (rx_packed() !== exp_pkt(16'hBEEF, 16'h0102, 8'hB0))
            begin n_fail++; $display("FAIL stall_bytes: got %h want %h", rx_packed(), exp_pkt(16'hBEEF, 16'h0102, 8'hB0)); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_overflow();
        int acc;
        bit done_seen;
        rx_q.delete();
        acc = 0;
        done_seen = 1'b0;
        @(negedge clk);
        word_valid = 1'b1;
        word_in    = 16'h0001;
        for (int i = 0; i < 3000; i++) begin
            if (pkt_done) begin
                done_seen = 1'b1;
                break;
            end
            if (word_ready) acc++;
            @(negedge clk);
            word_in = word_in + 16'h0001;
        end
        word_valid = 1'b0;
        n_checks += 4;
        if (done_seen !== 1'b1) begin n_fail++; $display("FAIL ovf_timeout: got %b want 1", done_seen); end
        if (acc !== NumWords) begin n_fail++; $display("FAIL ovf_accepts: got %0d want %0d", acc, NumWords); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        if (rx_packed() !== exp_pkt(16'h0001, 16'h0002, 8'h03))
            begin n_fail++; $display("FAIL ovf_bytes: got %h want %h", rx_packed(), exp_pkt(16'h0001, 16'h0002, 8'h03)); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_mid();
        int base;
        bit hit;
        bit ok;
        rx_q.delete();
        hit = 1'b0;
        send_pair(16'h1122, 16'h3344);
        for (int i = 0; i < 3000; i++) begin
            if (ld_tx_data === 1'b1 && tx_data === 8'h22) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL mid_reach_byte3: got %b want 1", hit); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks += 5;
        if (ld_tx_data !== 1'b0) begin n_fail++; $display("FAIL mid_ld: got %b want 0", ld_tx_data); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (word_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", word_ready); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b want 0", overflow); end
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
        for (int i = 0; i < 100 && tx_empty !== 1'b1; i++) @(negedge clk);
        rx_q.delete();
        base = pkt_cnt;
        send_pair(16'h5A5A, 16'h0F0F);
        wait_done(base, ok);
        n_checks += 2;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_fresh_timeout: got %b want 1", ok); end
        if (rx_packed() !== exp_pkt(16'h5A5A, 16'h0F0F, 8'hD2))
            begin n_fail++; $display("FAIL mid_fresh_bytes: got %h want %h", rx_packed(), exp_pkt(16'h5A5A, 16'h0F0F, 8'hD2)); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_wrap();
        int base;
        bit ok;
        rx_q.delete();
        base = pkt_cnt;
        send_pair(16'hFFFF, 16'hFFFF);
        wait_done(base, ok);
        n_checks += 2;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_timeout: got %b want 1", ok); end
        if (rx_packed() !== exp_pkt(16'hFFFF, 16'hFFFF, 8'hFC))
            begin n_fail++; $display("FAIL wrap_bytes: got %h want %h", rx_packed(), exp_pkt(16'hFFFF, 16'hFFFF, 8'hFC)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart2_tx_packetizer.md
Name: uart2_tx_packetizer

Overview:
Upstream feeder for the 8-bit UART transmitter. It collects NUM_WORDS parallel data words (e.g. ADC/feedback samples) into a packet buffer, then streams them out byte by byte. Each packet is a sync header byte, the payload bytes MSB-first, and an optional checksum byte. It drives the transmitter's load/empty handshake, holding each byte until the transmitter accepts it.

Parameters:
WORD_WIDTH, 16, payload word width; must be a multiple of 8 (8..32)
NUM_WORDS, 4, words per packet (1..16)
HEADER, 8'hA5, sync byte sent first in every packet

Ports:
clk  input  1  system clock (40 MHz)
reset  input  1  synchronous, active-high reset
word_in  input  WORD_WIDTH  payload word
word_valid  input  1  word_in valid this cycle
word_ready  output  1  block accepts word_in this cycle
tx_empty  input  1  transmitter idle flag (1 = idle)
ld_tx_data  output  1  request the transmitter to load tx_data
tx_data  output  8  byte presented to the transmitter
busy  output  1  packet transmission in progress
pkt_done  output  1  one-cycle pulse after the last byte of a packet is accepted and sent
overflow  output  1  sticky; a word was offered while word_ready=0

Behaviour:
- Reset values: word_ready=1, ld_tx_data=0, tx_data=8'h00, busy=0, pkt_done=0, overflow=0. Word count, byte index and checksum are 0. State is COLLECT.
- BPW = WORD_WIDTH/8. Packet length L = 1 + NUM_WORDS*BPW (+1 with checksum).
- COLLECT: word_ready=1 while word count < NUM_WORDS. Accept on word_valid && word_ready into buffer[count], then count++. On the cycle the NUM_WORDS-th word is accepted: word_ready falls next cycle, busy rises, and state goes to LOAD with tx_data=HEADER. ld_tx_data=1 on the cycle after the last accept (latency 1).
- LOAD: ld_tx_data=1, tx_data held stable. Leave for WAIT_IDLE on the first cycle tx_empty=0 is sampled; ld_tx_data drops the following cycle. No timeout: if the transmitter is disabled, LOAD holds indefinitely.
- WAIT_IDLE: ld_tx_data=0. Wait for tx_empty=1. Then, if more bytes remain, advance the byte index, present the next byte and go to LOAD. Otherwise pulse pkt_done, clear busy, set word_ready=1, clear count and checksum, and return to COLLECT.
- Byte order: header, then word 0 MSB..LSB, word 1, ... Byte selection is a pure index into the buffer; the buffer is not modified during transmission.
- Checksum (feature on): 8-bit sum modulo 256 of all payload bytes, header excluded. It is accumulated as bytes are presented.
- Overflow: word_valid=1 while word_ready=0 drops the word and sets overflow. Overflow is cleared only by reset. A word offered on the same cycle the buffer fills is accepted normally.
- word_valid during LOAD/WAIT_IDLE is never buffered (no double buffering).
- Reset mid-packet: immediate return to COLLECT with reset values and the partial packet discarded. The transmitter may still finish its current byte.

Optional Feature:
Macro UART_PKT_CHECKSUM_EN.
- Defined: a checksum byte is appended after the payload, so L = 2 + NUM_WORDS*BPW.
- Undefined: no checksum byte and no accumulator logic, so L = 1 + NUM_WORDS*BPW. The last payload byte directly precedes pkt_done.

Decomposition:
- Shared package/include: HEADER default, state encodings (COLLECT, LOAD, WAIT_IDLE), the bits_to_fit width function for count/index sizing.
- No sub-module: byte select mux, FSM and accumulator stay in one module. The bench instantiates the existing UART transmitter downstream plus a serial monitor.

Test Plan:
- WORD_WIDTH=16, NUM_WORDS=2, checksum on; words 16'h1234, 16'hABCD -> serial bytes A5 12 34 AB CD BE, pkt_done once, busy low after.
- Same with macro undefined -> bytes A5 12 34 AB CD only; pkt_done follows byte CD.
- Transmitter tx_enable held low for 1000 cycles with a full buffer -> ld_tx_data stays 1, tx_data=A5 stable; release -> packet completes intact.
- word_valid held continuously through a packet -> exactly NUM_WORDS words accepted, overflow=1, next packet collects only after pkt_done.
- Assert reset while the 3rd byte is in LOAD -> next cycle ld_tx_data=0, busy=0, word_ready=1; a fresh packet then transmits correctly starting with A5.
- Words 16'hFFFF x4 (NUM_WORDS=4) -> checksum byte 8'hF8 (wrap-around check).
